// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and types for the GPIO pad controller.
// Register indices, the bus FSM state type and the channel-count limit.
package gpio_pkg;

    localparam logic [2:0] REG_IN   = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_SEL  = 3'd2;
    localparam logic [2:0] REG_SET  = 3'd3;
    localparam logic [2:0] REG_CLR  = 3'd4;
    localparam logic [2:0] REG_RISE = 3'd5;
    localparam logic [2:0] REG_FALL = 3'd6;
    localparam logic [2:0] REG_STAT = 3'd7;

    localparam int NPINS_MAX = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/gpio_mux_ctrl_if.sv
// gpio_mux_ctrl_if: SoC valid/ready memory-mapped bus as seen by the GPIO block.
// master = SoC core side, slave = gpio_mux_ctrl side.
interface gpio_mux_ctrl_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: per-pin input synchroniser chain plus a one-cycle-delayed copy
// of the synchronised value, used by the parent for edge detection.
module gpio_sync #(
    parameter int NPINS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPINS-1:0] pad_in,
    output logic [NPINS-1:0] sync_out,
    output logic [NPINS-1:0] prev_out
);

    logic [NPINS-1:0] chain [SYNC_STAGES];

    // Shift raw pads through the chain; prev follows the last stage by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev_out <= '0;
        end else begin
            chain[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev_out <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_mux_ctrl.sv
// gpio_mux_ctrl: GPIO / fixed-function pad mux with register file and
// optional edge interrupts (build macro GPIO_IRQ_EN).
//
// Bus FSM:
//   state   | meaning
//   ST_IDLE | waiting for mem_valid; read data is captured on leaving
//   ST_ACK  | mem_ready high for one cycle, write applied at the end
module gpio_mux_ctrl
    import gpio_pkg::*;
#(
    parameter int NPINS       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_mux_ctrl_if.slave   bus,
    input  logic [NPINS-1:0] func_out,
    input  logic [NPINS-1:0] pad_in,
    output logic [NPINS-1:0] pad_out,
    output logic             irq
);

    bus_state_t       state;
    logic [NPINS-1:0] out_q;
    logic [NPINS-1:0] sel_q;
    logic [NPINS-1:0] in_sync;
    logic [NPINS-1:0] in_prev;
    logic [31:0]      bmask;
    logic [31:0]      wbits32;
    logic [NPINS-1:0] wmask;
    logic [NPINS-1:0] wbits;
    logic             wr_en;
    logic [2:0]       idx;
    logic [NPINS-1:0] rd_pins;
    logic [31:0]      rd_val;
    logic             unused_ok;

    gpio_sync #(
        .NPINS       (NPINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pad_in   (pad_in),
        .sync_out (in_sync),
        .prev_out (in_prev)
    );

    assign idx     = bus.mem_addr[4:2];
    assign bmask   = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                      {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
    assign wbits32 = bus.mem_wdata & bmask;
    assign wmask   = bmask[NPINS-1:0];
    assign wbits   = wbits32[NPINS-1:0];
    assign wr_en   = (state == ST_ACK) && (bus.mem_wstrb != 4'b0000);

    // Pad ownership: GPIO where SEL is set, SoC function elsewhere.
    assign pad_out = (out_q & sel_q) | (func_out & ~sel_q);

`ifdef GPIO_IRQ_EN
    localparam int ARM_MAX = SYNC_STAGES + 1;

    logic [2:0]       arm_cnt;
    logic             armed;
    logic [NPINS-1:0] rise_en;
    logic [NPINS-1:0] fall_en;
    logic [NPINS-1:0] irq_stat;
    logic [NPINS-1:0] evt;
    logic [NPINS-1:0] w1c;

    assign armed = (arm_cnt == 3'(ARM_MAX));
    assign evt   = armed ? ((in_sync & ~in_prev & rise_en) |
                            (~in_sync & in_prev & fall_en)) : '0;
    assign w1c   = (wr_en && idx == REG_STAT) ? wbits : '0;
    assign irq   = |irq_stat;

    // Edge-enable registers, sticky status (hardware set beats W1C), arm counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt  <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_stat <= '0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            irq_stat <= (irq_stat & ~w1c) | evt;
            if (wr_en && idx == REG_RISE) begin
                rise_en <= (rise_en & ~wmask) | wbits;
            end
            if (wr_en && idx == REG_FALL) begin
                fall_en <= (fall_en & ~wmask) | wbits;
            end
        end
    end
`else
    logic unused_prev;
    assign unused_prev = ^in_prev;
    assign irq         = 1'b0;
`endif

    // Read decode; write-only and absent registers return zero.
    always_comb begin
        rd_pins = '0;
        rd_val  = '0;
        case (idx)
            REG_IN:   rd_pins = in_sync;
            REG_OUT:  rd_pins = out_q;
            REG_SEL:  rd_pins = sel_q;
`ifdef GPIO_IRQ_EN
            REG_RISE: rd_pins = rise_en;
            REG_FALL: rd_pins = fall_en;
            REG_STAT: rd_pins = irq_stat;
`endif
            default:  rd_pins = '0;
        endcase
        rd_val[NPINS-1:0] = rd_pins;
    end

    // Bus handshake: capture read data entering ACK, hold ready for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.mem_valid) begin
                        state         <= ST_ACK;
                        bus.mem_ready <= 1'b1;
                        bus.mem_rdata <= rd_val;
                    end
                end
                ST_ACK: begin
                    state         <= ST_IDLE;
                    bus.mem_ready <= 1'b0;
                    bus.mem_rdata <= '0;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.mem_ready <= 1'b0;
                    bus.mem_rdata <= '0;
                end
            endcase
        end
    end

    // OUT and SEL register writes, including the set/clear aliases of OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= '0;
        end else if (wr_en) begin
            case (idx)
                REG_OUT: out_q <= (out_q & ~wmask) | wbits;
                REG_SEL: sel_q <= (sel_q & ~wmask) | wbits;
                REG_SET: out_q <= out_q | wbits;
                REG_CLR: out_q <= out_q & ~wbits;
                default: ;
            endcase
        end
    end

    assign unused_ok = ^{bus.mem_addr[1:0], bmask, wbits32};

endmodule

// File: doc/gpio_mux_ctrl.md
# gpio_mux_ctrl

Parametrised GPIO controller that sits between the SoC core and the TinyTapeout dedicated I/O pads. It owns NPINS bidirectional-capable channels. Each channel's pad output is either the SoC's fixed-function signal or a software-driven GPIO bit, chosen per pin by a select register. Input pins are synchronised, and programmable rising and falling edge detection raises a level interrupt. Software reaches the block through the SoC's valid/ready memory-mapped bus.

## Interface
- NPINS, 8: channel count, 1..32; register bits above NPINS-1 read 0 and ignore writes.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- clk  in  1  system clock, the single clock domain.
- rst  in  1  reset, synchronous, active-high.
- mem_valid  in  1  bus request.
- mem_ready  out  1  one-cycle completion strobe.
- mem_addr  in  5  byte address; register index = mem_addr[4:2].
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data, valid while mem_ready=1, otherwise 0.
- func_out  in  NPINS  SoC fixed-function pad drive.
- pad_in  in  NPINS  raw asynchronous pad inputs.
- pad_out  out  NPINS  pad drive = (gpio_out & gpio_sel) | (func_out & ~gpio_sel).
- irq  out  1  level interrupt = |irq_stat.

## Operation
- Register map, by index:
  - 0 IN: synchronised inputs, read-only.
  - 1 OUT: read/write.
  - 2 SEL: per-pin override; 1 selects GPIO.
  - 3 OUT_SET: write-only; OUT |= wdata.
  - 4 OUT_CLR: write-only; OUT &= ~wdata.
  - 5 RISE_EN: read/write.
  - 6 FALL_EN: read/write.
  - 7 IRQ_STAT: writing 1 clears the bit.
- Write-only registers read as 0. Byte strobes apply per byte on every writable register.
- Bus FSM states:
  - IDLE: on mem_valid=1, move to ACK.
  - ACK: assert mem_ready for one cycle, perform the write or register the read data, return to IDLE.
  - mem_valid must stay high until mem_ready. Back-to-back requests therefore complete every 2 cycles.
- Synchroniser: a chain of SYNC_STAGES flops per pin. The last stage is IN. A prev register holds IN delayed by one cycle.
- Edge events:
  - rise = IN & ~prev & RISE_EN
  - fall = ~IN & prev & FALL_EN
  - irq_stat |= rise | fall every cycle.
- Simultaneous hardware set and W1C on the same bit: set wins, and the bit stays 1.
- Clearing RISE_EN or FALL_EN does not clear pending status bits.
- Arming: an arm counter runs from 0 to SYNC_STAGES+1 after reset. Edge events are suppressed until it saturates. This stops reset-time pad levels from appearing as edges.

## Timing
- Reset values:
  - mem_ready=0, mem_rdata=0.
  - OUT, SEL, RISE_EN, FALL_EN, IRQ_STAT all 0.
  - sync chain and prev 0, arm counter 0.
  - Resulting outputs: pad_out = func_out, irq=0.
- Bus: mem_valid rising in cycle N gives mem_ready and rdata in cycle N+1. A write takes effect on the register at the N+1 edge, so pad_out reflects it from cycle N+2.
- pad_out is combinational from registers and func_out. There is no added latency on the func_out path.
- Pad change sampled at edge E appears in IN after SYNC_STAGES edges. The irq_stat bit and irq follow one edge later.
- rst asserted during ACK: mem_ready=0 on the next cycle, the write is discarded and the FSM goes to IDLE.

## Configuration
- GPIO_IRQ_EN:
  - Defined: edge detection, RISE_EN, FALL_EN, IRQ_STAT, arm counter and irq are built.
  - Undefined: that logic is removed. Indices 5–7 read 0 and ignore writes, irq is tied to 0. IN, OUT, SEL, SET/CLR and the pad mux are unchanged.

## Structure
- Package gpio_pkg holds:
  - register index localparams: REG_IN, REG_OUT, REG_SEL, REG_SET, REG_CLR, REG_RISE, REG_FALL, REG_STAT
  - the bus FSM state enum
  - the maximum NPINS constant
- One sub-module, gpio_sync: a per-pin SYNC_STAGES-deep flop chain plus the prev register, instantiated as an NPINS-wide vector.
- The register file, bus FSM, edge/IRQ logic and pad mux all live in gpio_mux_ctrl.

## Test plan
- Reset with func_out=8'hA5 and pad_in=8'hFF:
  - pad_out=8'hA5, irq=0, all reads 0.
  - No IRQ_STAT bit is set after 10 cycles, even with RISE_EN=8'hFF written right after reset.
- Mux select: write OUT=8'h0F and SEL=8'hF0 with func_out=8'h3C → pad_out=8'h0C. Then write OUT_SET=8'hF0 → pad_out=8'hFC.
- Rising edge: with RISE_EN=8'h01, pad_in[0] goes 0→1 → IN[0]=1 after 2 edges, irq=1 after 3 edges. Writing IRQ_STAT=1 drops irq the following cycle.
- Clear race: hold a fall event on pin 3 in the same cycle as a W1C write of 8'h08 → IRQ_STAT[3] remains 1.
- Byte strobes: write OUT=32'hFFFF_FFFF with wstrb=4'b0001 at NPINS=16 → OUT reads 32'h0000_00FF.
- Reset mid-ACK: assert rst during the ACK cycle of a write to SEL → SEL stays 0, mem_ready=0 the next cycle, and a fresh read then completes normally.
